// File: rtl/csa_accumulator.sv
// ----------------------------------------------------------------------------
// csa_accumulator
//
// Sequential carry-save accumulator for the Wallace-tree multiplier datapath.
// It takes one operand per cycle over a valid/ready handshake and folds it
// into a redundant sum/carry pair using one 3:2 full-adder row. Because the
// pair stays in redundant form, no carry ripples while the block accumulates.
// When the operand marked "last" is accepted, the block spends one cycle on a
// single carry-propagate add. It then presents the resolved sum and the
// operand count on a valid/ready output port.
//
// Ports
//   clk        in   1         clock; every register updates on the rising edge
//   rst        in   1         asynchronous, active-high reset
//   in_valid   in   1         operand valid
//   in_ready   out  1         block can accept an operand (state only)
//   in_data    in   IN_WIDTH  operand
//   in_last    in   1         marks the final operand of a sequence
//   out_valid  out  1         result valid
//   out_ready  in   1         consumer accepts the result
//   out_data   out  WIDTH     resolved sum of the sequence, modulo 2^WIDTH
//   out_count  out  CNT_W     operands in the sequence, saturating
// ----------------------------------------------------------------------------
module csa_accumulator #(
    parameter int WIDTH    = 66,
    parameter int IN_WIDTH = 64,
    parameter int SIGNED   = 1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [CNT_W-1:0]    out_count
);

    typedef enum logic [1:0] {
        ST_ACC     = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   carry_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic [CNT_W-1:0]   out_count_reg;

    logic [WIDTH-1:0]   x_ext;
    logic [WIDTH-1:0]   sum_next;
    logic [WIDTH-1:0]   carry_next;
    logic [WIDTH-1:0]   resolved;
    logic [CNT_W-1:0]   count_next;
    logic               accept;

    // ------------------------------------------------------------------
    // Operand extension to the accumulator width
    // ------------------------------------------------------------------
    generate
        if (WIDTH > IN_WIDTH) begin : g_ext
            logic fill_bit;
            assign fill_bit = (SIGNED != 0) ? in_data[IN_WIDTH-1] : 1'b0;
            assign x_ext    = {{(WIDTH-IN_WIDTH){fill_bit}}, in_data};
        end else begin : g_noext
            assign x_ext = in_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // 3:2 compressor row. The majority output of bit gi feeds carry bit
    // gi+1. The majority output of the top bit has no destination: that
    // carry is dropped, which is what makes the arithmetic wrap modulo
    // 2^WIDTH.
    // ------------------------------------------------------------------
    assign carry_next[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa_row
            assign sum_next[gi] = sum_reg[gi] ^ carry_reg[gi] ^ x_ext[gi];
            if (gi < WIDTH - 1) begin : g_maj
                assign carry_next[gi+1] = (sum_reg[gi] & carry_reg[gi]) |
                                          (sum_reg[gi] & x_ext[gi])     |
                                          (carry_reg[gi] & x_ext[gi]);
            end
        end
    endgenerate

    // The single carry-propagate add, used only in the resolve cycle.
    assign resolved = sum_reg + carry_reg;

    // Saturating operand counter.
    assign count_next = (count_reg == {CNT_W{1'b1}}) ? count_reg
                                                     : count_reg + CNT_W'(1);

    assign accept = in_valid & in_ready_reg;

    // ------------------------------------------------------------------
    // Control FSM together with the datapath registers. in_ready is
    // registered and tracks the state, so it never depends on in_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_ACC;
            sum_reg       <= '0;
            carry_reg     <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        sum_reg   <= sum_next;
                        carry_reg <= carry_next;
                        count_reg <= count_next;
                        if (in_last) begin
                            state_reg    <= ST_RESOLVE;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    out_data_reg  <= resolved;
                    out_count_reg <= count_reg;
                    out_valid_reg <= 1'b1;
                    // Clear the redundant pair so the next sequence starts clean.
                    sum_reg       <= '0;
                    carry_reg     <= '0;
                    count_reg     <= '0;
                    state_reg     <= ST_OUT;
                end
                ST_OUT: begin
                    // The result stays put until it is consumed; no retraction.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_ACC;
                    end
                end
                default: begin
                    state_reg     <= ST_ACC;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_csa_accumulator.sv
// ----------------------------------------------------------------------------
// tb_csa_accumulator
//
// Self-checking bench for csa_accumulator. It runs three configurations side
// by side:
//   dut 0 : WIDTH=66, IN_WIDTH=64, SIGNED=1, CNT_W=8
//   dut 1 : WIDTH=66, IN_WIDTH=64, SIGNED=0, CNT_W=8
//   dut 2 : WIDTH=8,  IN_WIDTH=8,  SIGNED=0, CNT_W=2
// One shared stimulus bus is steered to the DUT picked by sel.
// ----------------------------------------------------------------------------
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic        valid;
    logic        last;
    logic        oready;
    logic [63:0] data;

    logic        v0, v1, v2, or0, or1, or2;
    logic        r0, r1, r2, ov0, ov1, ov2;
    logic [65:0] od0, od1;
    logic [7:0]  od2;
    logic [7:0]  oc0, oc1;
    logic [1:0]  oc2;

    logic        cur_ready, cur_ov;
    logic [65:0] cur_od;
    logic [7:0]  cur_oc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign v0  = valid  & (sel == 2'd0);
    assign v1  = valid  & (sel == 2'd1);
    assign v2  = valid  & (sel == 2'd2);
    assign or0 = oready & (sel == 2'd0);
    assign or1 = oready & (sel == 2'd1);
    assign or2 = oready & (sel == 2'd2);

    csa_accumulator #(.WIDTH(66), .IN_WIDTH(64), .SIGNED(1), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(data),
        .in_last(last), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .out_count(oc0));

    csa_accumulator #(.WIDTH(66), .IN_WIDTH(64), .SIGNED(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(data),
        .in_last(last), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .out_count(oc1));

    csa_accumulator #(.WIDTH(8), .IN_WIDTH(8), .SIGNED(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(data[7:0]),
        .in_last(last), .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .out_count(oc2));

    always_comb begin
        cur_ready = r0;
        cur_ov    = ov0;
        cur_od    = od0;
        cur_oc    = oc0;
        if (sel == 2'd1) begin
            cur_ready = r1;
            cur_ov    = ov1;
            cur_od    = od1;
            cur_oc    = oc1;
        end else if (sel == 2'd2) begin
            cur_ready = r2;
            cur_ov    = ov2;
            cur_od    = {58'd0, od2};
            cur_oc    = {6'd0, oc2};
        end
    end

    task automatic check_val(input string tag, input logic [65:0] got,
                             input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one operand; hold it until accepted; drop valid half a cycle
    // after the accepting edge.
    task automatic send(input logic [63:0] d, input logic l);
        int waited = 0;
        @(negedge clk);
        data  = d;
        last  = l;
        valid = 1'b1;
        while (!cur_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cur_ready) check_val("in_ready_wait", 66'(cur_ready), 66'd1);
        else @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [65:0] ed,
                              input logic [7:0] ec);
        int waited = 0;
        while (!cur_ov && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, "_valid"}, 66'(cur_ov), 66'd1);
        check_val({tag, "_data"}, cur_od, ed);
        check_val({tag, "_count"}, 66'(cur_oc), 66'(ec));
        $display("result %s dut%0d data=%h count=%0d", tag, sel, cur_od, cur_oc);
        oready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        oready = 1'b0;
        check_val({tag, "_drop"}, 66'(cur_ov), 66'd0);
        check_val({tag, "_rdy"}, 66'(cur_ready), 66'd1);
    endtask

    initial begin
        logic [65:0] ref_sum;
        logic [63:0] d;
        int          n;

        rst = 1'b1; sel = 2'd0; valid = 1'b0; last = 1'b0; oready = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("init_rdy", 66'(cur_ready), 66'd1);
        check_val("init_ov", 66'(cur_ov), 66'd0);

        // 1: asynchronous reset while a result is pending
        sel = 2'd0;
        send(64'd5, 1'b1);
        @(negedge clk);
        check_val("pre_rst_ov", 66'(cur_ov), 66'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_ov", 66'(cur_ov), 66'd0);
        check_val("rst_od", cur_od, 66'd0);
        check_val("rst_oc", 66'(cur_oc), 66'd0);
        check_val("rst_rdy", 66'(cur_ready), 66'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_rdy", 66'(cur_ready), 66'd1);
        check_val("post_rst_ov", 66'(cur_ov), 66'd0);

        // 2: unsigned 5 + 7 + 9 with latency check
        sel = 2'd1;
        send(64'd5, 1'b0);
        send(64'd7, 1'b0);
        send(64'd9, 1'b1);
        check_val("lat_ov_t1", 66'(cur_ov), 66'd0);
        check_val("lat_rdy_t1", 66'(cur_ready), 66'd0);
        @(negedge clk);
        check_val("lat_ov_t2", 66'(cur_ov), 66'd1);
        get_result("unsigned3", 66'd21, 8'd3);

        // 3: all-ones plus two, signed then unsigned
        sel = 2'd0;
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd2, 1'b1);
        get_result("signed_m1p2", 66'd1, 8'd2);
        sel = 2'd1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd2, 1'b1);
        get_result("unsigned_m1p2", 66'h1_0000_0000_0000_0001, 8'd2);

        // 4: narrow configuration, wrap and count saturation
        sel = 2'd2;
        send(64'd200, 1'b0);
        send(64'd100, 1'b1);
        get_result("wrap8", 66'd44, 8'd2);
        for (int i = 0; i < 5; i++) send(64'd1, (i == 4));
        get_result("sat_cnt", 66'd5, 8'd3);

        // 5: output backpressure with in_valid pulsing
        sel = 2'd0;
        send(64'd11, 1'b0);
        send(64'd12, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_rdy", 66'(cur_ready), 66'd0);
            check_val("bp_ov", 66'(cur_ov), 66'd1);
            check_val("bp_od", cur_od, 66'd23);
            valid = (k % 2 == 0);
            data  = 64'd99;
            last  = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        get_result("bp_hold", 66'd23, 8'd2);
        send(64'd3, 1'b1);
        get_result("bp_after", 66'd3, 8'd1);

        // 6: reset in the middle of a sequence
        send(64'd10, 1'b0);
        send(64'd20, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(64'd4, 1'b1);
        get_result("mid_rst", 66'd4, 8'd1);

        // Random sequences on every configuration against a reference sum
        for (int s = 0; s < 3; s++) begin
            sel = s[1:0];
            for (int q = 0; q < 4; q++) begin
                n = $urandom_range(1, 6);
                ref_sum = '0;
                for (int i = 0; i < n; i++) begin
                    d = {$urandom, $urandom};
                    if (s == 0)      ref_sum = ref_sum + {{2{d[63]}}, d};
                    else if (s == 1) ref_sum = ref_sum + {2'b00, d};
                    else             ref_sum = ref_sum + {58'd0, d[7:0]};
                    send(d, (i == n - 1));
                end
                if (s == 2) begin
                    ref_sum = {58'd0, ref_sum[7:0]};
                    get_result("rand", ref_sum, (n > 3) ? 8'd3 : 8'(n));
                end else begin
                    get_result("rand", ref_sum, 8'(n));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
